// File: rtl/conv_weight_loader.sv
// Serial weight stream -> NUM per-channel weight stores, NW taps each, channel 0 first.
// Optional stall timeout with sticky error: define WLOAD_TIMEOUT_EN.
module conv_weight_loader #(
   parameter  int WD     = 8,
   parameter  int NW     = 25,
   parameter  int NUM    = 6,
   parameter  int TO_CYC = 1024,
   localparam int AW     = $clog2(NW),
   localparam int CW     = (NUM > 1) ? $clog2(NUM) : 1
) (
   input  logic              i_sclk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [WD-1:0]     i_wdata,
   input  logic              i_wvalid,
   output logic              o_wready,
   output logic [NUM-1:0]    o_w_en,
   output logic [NUM*WD-1:0] o_w_data,
   output logic [AW-1:0]     o_w_addr,
   output logic [CW-1:0]     o_ch_idx,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);

   if (NW < 2 || NUM < 1 || TO_CYC < 2) begin : g_param_chk
      $error("conv_weight_loader: NW must be >= 2, NUM >= 1, TO_CYC >= 2");
   end

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   state_t              r_state;
   logic [AW-1:0]       r_tap;
   logic [CW-1:0]       r_ch;
   logic [NUM-1:0]      r_w_en;
   logic [NUM*WD-1:0]   r_w_data;
   logic [AW-1:0]       r_w_addr;
   logic [CW-1:0]       r_ch_idx;

   logic w_acc;
   logic w_last_tap;
   logic w_last_ch;
   logic w_timeout;

   // Abort gates ready combinationally so a beat offered in the abort cycle is never taken.
   assign o_wready   = (r_state == S_LOAD) && !i_abort;
   assign w_acc      = i_wvalid && o_wready;
   assign w_last_tap = (r_tap == AW'(NW - 1));
   assign w_last_ch  = (r_ch == CW'(NUM - 1));

`ifdef WLOAD_TIMEOUT_EN
   localparam int SW = $clog2(TO_CYC) + 1;

   logic [SW-1:0] r_stall;
   logic          r_err;

   // Abort takes priority, so a timeout is never flagged in an abort cycle.
   assign w_timeout = (r_state == S_LOAD) && !w_acc && !i_abort &&
                      (r_stall == SW'(TO_CYC - 1));

   always_ff @(posedge i_sclk or posedge i_rst) begin
      if (i_rst) begin
         r_stall <= '0;
      end else if (r_state != S_LOAD || w_acc) begin
         r_stall <= '0;
      end else begin
         r_stall <= r_stall + SW'(1);
      end
   end

   always_ff @(posedge i_sclk or posedge i_rst) begin
      if (i_rst) begin
         r_err <= 1'b0;
      end else if (r_state == S_IDLE && i_start) begin
         r_err <= 1'b0;
      end else if (w_timeout) begin
         r_err <= 1'b1;
      end
   end

   assign o_err = r_err;
`else
   assign w_timeout = 1'b0;
   assign o_err     = 1'b0;
`endif

   always_ff @(posedge i_sclk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_tap    <= '0;
         r_ch     <= '0;
         r_w_en   <= '0;
         r_w_data <= '0;
         r_w_addr <= '0;
         r_ch_idx <= '0;
      end else begin
         r_w_en   <= '0;
         r_w_data <= '0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state <= S_LOAD;
                  r_tap   <= '0;
                  r_ch    <= '0;
               end
            end
            S_LOAD: begin
               if (i_abort || w_timeout) begin
                  r_state <= S_IDLE;
                  r_tap   <= '0;
                  r_ch    <= '0;
               end else if (w_acc) begin
                  for (int c = 0; c < NUM; c++) begin
                     if (r_ch == CW'(c)) begin
                        r_w_en[c]             <= 1'b1;
                        r_w_data[c*WD +: WD]  <= i_wdata;
                     end
                  end
                  r_w_addr <= r_tap;
                  r_ch_idx <= r_ch;
                  if (w_last_tap) begin
                     r_tap <= '0;
                     if (w_last_ch) begin
                        r_ch    <= '0;
                        r_state <= S_DONE;
                     end else begin
                        r_ch <= r_ch + CW'(1);
                     end
                  end else begin
                     r_tap <= r_tap + AW'(1);
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // DONE lasts exactly the cycle in which the final write is presented.
   assign o_w_en   = r_w_en;
   assign o_w_data = r_w_data;
   assign o_w_addr = r_w_addr;
   assign o_ch_idx = r_ch_idx;
   assign o_busy   = (r_state == S_LOAD);
   assign o_done   = (r_state == S_DONE);

endmodule

// File: tb/tb_conv_weight_loader.sv
// Bench for conv_weight_loader: beat-count model checked every cycle, plus literal spot checks.
module tb_conv_weight_loader;
   localparam int WD  = 8;
   localparam int NW  = 25;
   localparam int NUM = 6;
   localparam int AW  = 5;
   localparam int CW  = 3;
`ifdef WLOAD_TIMEOUT_EN
   localparam int TO = 16;
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam int TO = 1024;
   localparam bit TIMEOUT_ON = 1'b0;
`endif

   logic              i_sclk = 1'b0;
   logic              i_rst = 1'b1;
   logic              i_start = 1'b0;
   logic              i_abort = 1'b0;
   logic              i_wvalid = 1'b0;
   logic [WD-1:0]     i_wdata = '0;
   logic              o_wready;
   logic [NUM-1:0]    o_w_en;
   logic [NUM*WD-1:0] o_w_data;
   logic [AW-1:0]     o_w_addr;
   logic [CW-1:0]     o_ch_idx;
   logic              o_busy;
   logic              o_done;
   logic              o_err;

   conv_weight_loader #(.WD(WD), .NW(NW), .NUM(NUM), .TO_CYC(TO)) dut (
      .i_sclk(i_sclk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
      .i_wdata(i_wdata), .i_wvalid(i_wvalid), .o_wready(o_wready),
      .o_w_en(o_w_en), .o_w_data(o_w_data), .o_w_addr(o_w_addr),
      .o_ch_idx(o_ch_idx), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
   );

   always #5 i_sclk = ~i_sclk;

   int total = 0;
   int bad   = 0;
   int n_wr  = 0;
   int n_done = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a load is a count of accepted beats; beat k lands in channel k/NW at tap k%NW.
   bit                m_load, m_indone, m_err, m_prev_done, m_acc;
   int                m_cnt, m_stall, m_c;
   logic [NUM-1:0]    e_en;
   logic [NUM*WD-1:0] e_data;
   logic [AW-1:0]     e_addr;
   logic [CW-1:0]     e_ch;

   always @(posedge i_sclk) begin
      if (i_rst) begin
         m_load = 0; m_indone = 0; m_err = 0; m_cnt = 0; m_stall = 0;
         e_en = '0; e_data = '0; e_addr = '0; e_ch = '0;
      end else begin
         chk("wready", o_wready, m_load && !i_abort);
         m_acc = m_load && !i_abort && i_wvalid;
         e_en = '0;
         e_data = '0;
         if (m_acc) begin
            m_c = m_cnt / NW;
            e_en[m_c] = 1'b1;
            e_data[m_c*WD +: WD] = i_wdata;
            e_addr = AW'(m_cnt % NW);
            e_ch = CW'(m_c);
         end
         m_prev_done = m_indone;
         m_indone = 0;
         if (m_load) begin
            if (i_abort) m_load = 0;
            else if (m_acc) begin
               m_stall = 0;
               if (m_cnt == NW*NUM-1) begin m_load = 0; m_indone = 1; end
               m_cnt++;
            end else if (TIMEOUT_ON) begin
               if (m_stall == TO-1) begin m_load = 0; m_err = 1; end
               else m_stall++;
            end
         end else if (!m_prev_done && i_start) begin
            m_load = 1; m_cnt = 0; m_stall = 0; m_err = 0;
         end
      end
      #1;
      if (o_w_en != '0) n_wr++;
      if (o_done) n_done++;
      chk("m_w_en", o_w_en, e_en);
      chk("m_w_data", o_w_data, e_data);
      chk("m_w_addr", o_w_addr, e_addr);
      chk("m_ch_idx", o_ch_idx, e_ch);
      chk("m_done", o_done, m_indone);
      chk("m_busy", o_busy, m_load);
      chk("m_err", o_err, m_err);
   end

   task automatic cyc(input bit st, input bit ab, input bit v, input logic [7:0] d);
      @(negedge i_sclk);
      i_start = st; i_abort = ab; i_wvalid = v; i_wdata = d;
   endtask

   task automatic post();
      @(posedge i_sclk);
      #2;
   endtask

   task automatic wr_lit(input string nm, input logic [NUM-1:0] en, input int addr,
                         input int ch, input logic [7:0] d);
      chk({nm, "_en"}, o_w_en, en);
      chk({nm, "_addr"}, o_w_addr, addr);
      chk({nm, "_ch"}, o_ch_idx, ch);
      chk({nm, "_data"}, o_w_data[ch*WD +: WD], d);
   endtask

   task automatic all_zero(input string nm);
      chk({nm, "_en"}, o_w_en, 0);
      chk({nm, "_data"}, o_w_data, 0);
      chk({nm, "_addr"}, o_w_addr, 0);
      chk({nm, "_ch"}, o_ch_idx, 0);
      chk({nm, "_busy"}, o_busy, 0);
      chk({nm, "_done"}, o_done, 0);
      chk({nm, "_wready"}, o_wready, 0);
      chk({nm, "_err"}, o_err, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge i_sclk);
      #2;
      all_zero("reset");
      @(negedge i_sclk);
      i_rst = 1'b0;

      // back-to-back full load
      n_wr = 0; n_done = 0;
      cyc(1, 0, 0, 0);
      for (int k = 0; k < 150; k++) begin
         cyc(0, 0, 1, 8'(k));
         if (k == 0)   begin post(); wr_lit("b2b0", 6'b000001, 0, 0, 8'h00); end
         if (k == 25)  begin post(); wr_lit("b2b25", 6'b000010, 0, 1, 8'h19); end
         if (k == 149) begin
            post(); wr_lit("b2b149", 6'b100000, 24, 5, 8'h95);
            chk("b2b_done", o_done, 1);
         end
      end
      cyc(0, 0, 0, 0);
      post();
      chk("b2b_idle_wready", o_wready, 0);
      chk("b2b_idle_busy", o_busy, 0);
      chk("b2b_nwr", n_wr, 150);
      chk("b2b_ndone", n_done, 1);

      // valid toggling every cycle
      n_wr = 0; n_done = 0;
      cyc(1, 0, 0, 0);
      for (int k = 0; k < 150; k++) begin
         cyc(0, 0, 1, 8'(k));
         if (k == 30) begin post(); wr_lit("tog30", 6'b000010, 5, 1, 8'h1E); end
         if (k < 149) begin
            cyc(0, 0, 0, 0);
            if (k == 10) begin post(); chk("tog_bubble_en", o_w_en, 0); end
         end
      end
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("tog_nwr", n_wr, 150);
      chk("tog_ndone", n_done, 1);

      // abort after 40 beats, with a beat offered in the abort cycle
      n_wr = 0; n_done = 0;
      cyc(1, 0, 0, 0);
      for (int k = 0; k < 40; k++) begin
         cyc(0, 0, 1, 8'(k));
         if (k == 39) begin post(); wr_lit("ab39", 6'b000010, 14, 1, 8'h27); end
      end
      cyc(0, 1, 1, 8'hAA);
      #1;
      chk("ab_wready", o_wready, 0);
      post();
      chk("ab_en", o_w_en, 0);
      chk("ab_busy", o_busy, 0);
      cyc(0, 0, 0, 0);
      post();
      chk("ab_ndone", n_done, 0);
      chk("ab_nwr", n_wr, 40);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 8'h5A);
      post();
      wr_lit("ab_restart", 6'b000001, 0, 0, 8'h5A);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);

      // mid-load start ignored, extra beat after done not accepted
      n_wr = 0; n_done = 0;
      cyc(1, 0, 0, 0);
      for (int k = 0; k < 150; k++) begin
         cyc(k == 60, 0, 1, 8'(k));
         if (k == 60)  begin post(); wr_lit("st60", 6'b000100, 10, 2, 8'h3C); end
         if (k == 149) begin post(); chk("st_done", o_done, 1); end
      end
      cyc(0, 0, 1, 8'hEE);
      #1;
      chk("st_extra_wready", o_wready, 0);
      post();
      chk("st_extra_en", o_w_en, 0);
      chk("st_busy", o_busy, 0);
      cyc(0, 0, 1, 8'hEF);
      post();
      chk("st_idle_en", o_w_en, 0);
      cyc(0, 0, 0, 0);
      chk("st_nwr", n_wr, 150);
      chk("st_ndone", n_done, 1);

      // async reset mid-load
      cyc(1, 0, 0, 0);
      for (int k = 0; k < 77; k++) cyc(0, 0, 1, 8'(k));
      cyc(0, 0, 1, 8'd77);
      #2 i_rst = 1'b1;
      #1 all_zero("arst");
      @(negedge i_sclk);
      @(negedge i_sclk);
      i_rst = 1'b0; i_wvalid = 1'b0;
      repeat (3) cyc(0, 0, 1, 8'h11);
      post();
      chk("arst_busy", o_busy, 0);
      chk("arst_wready", o_wready, 0);
      chk("arst_en", o_w_en, 0);
      cyc(0, 0, 0, 0);

`ifdef WLOAD_TIMEOUT_EN
      n_done = 0;
      cyc(1, 0, 0, 0);
      for (int k = 0; k <= 10; k++) cyc(0, 0, 1, 8'(k));
      repeat (16) cyc(0, 0, 0, 0);
      post();
      chk("to_err", o_err, 1);
      chk("to_busy", o_busy, 0);
      chk("to_ndone", n_done, 0);
      cyc(1, 0, 0, 0);
      post();
      chk("to_clear_err", o_err, 0);
      chk("to_restart_busy", o_busy, 1);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
`endif

      repeat (2) cyc(0, 0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/conv_weight_loader.md
Name: conv_weight_loader

Overview:
- Parametrised weight-distribution block for the conv layers: accepts one serial weight stream and scatters it, tap by tap, into NUM per-channel weight stores.
- Channel 0 receives its NW taps first, then channel 1, and so on.
- Adds a valid/ready handshake, a start/abort-controlled load FSM, a done pulse and a flat per-channel output bus.
- Sits between the weight DMA/stream source and the PE-array weight register files; one instance per conv layer (C1: NW=25, NUM=6).

Parameters:
- WD, 8, weight bit width.
- NW, 25, taps per output channel (kernel size squared); must be >= 2.
- NUM, 6, output channel count; must be >= 1.
- AW, $clog2(NW), tap address width (localparam; not overridable).
- CW, $clog2(NUM) (1 if NUM=1), channel index width (localparam).
- TO_CYC, 1024, stall timeout in cycles (used only with the optional feature).

Ports:
- i_sclk  in  1  system clock; all logic on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  single-cycle pulse: begin loading NW*NUM weights.
- i_abort  in  1  single-cycle pulse: terminate the current load.
- i_wdata  in  WD  weight beat.
- i_wvalid  in  1  beat valid.
- o_wready  out  1  block can accept a beat.
- o_w_en  out  NUM  one-hot write enable for the channel being written.
- o_w_data  out  NUM*WD  flat bus; slice c = [c*WD +: WD]. Carries the written weight in the enabled slice; all other slices are 0.
- o_w_addr  out  AW  tap index of the current write, 0..NW-1.
- o_ch_idx  out  CW  binary index of the current channel.
- o_busy  out  1  high while in LOAD.
- o_done  out  1  one-cycle pulse after the last weight is written.
- o_err  out  1  sticky timeout flag; cleared by i_start or reset.

Behaviour:
- Reset (async assert, sync release): state=IDLE; tap and channel counters=0; all outputs 0, including o_wready, o_w_en, o_w_data and o_err.
- FSM states: IDLE, LOAD, DONE.
- IDLE -> LOAD on i_start. Clears both counters and o_err.
- LOAD -> DONE when the beat with tap=NW-1 and ch=NUM-1 is accepted.
- LOAD -> IDLE on i_abort. No o_done. Counters cleared.
- DONE -> IDLE unconditionally after one cycle; o_done=1 in that cycle.
- o_wready = (state==LOAD) && !i_abort. Registered state, combinational abort gate.
- Beat acceptance = i_wvalid && o_wready. Only accepted beats advance the counters.
- Tap counter: 0..NW-1, wraps to 0 and increments the channel counter on NW-1.
- Channel counter: 0..NUM-1.
- Latency: exactly 1 cycle. An accepted beat in cycle t appears in cycle t+1 as:
  - o_w_en = 1<<ch;
  - o_w_data slice ch = i_wdata;
  - o_w_addr = tap; o_ch_idx = ch.
- With no accepted beat in cycle t, cycle t+1 has o_w_en=0 and o_w_data=0. o_w_addr and o_ch_idx hold their last value.
- o_done asserts in the same cycle as the final write's o_w_en.
- Bubbles (i_wvalid=0) in LOAD stall the counters without error (without the optional feature).
- i_start while in LOAD or DONE is ignored.
- i_abort in IDLE is ignored.
- i_start and i_abort in the same cycle in IDLE: start wins.
- i_abort in the same cycle as a valid beat in LOAD: the beat is not accepted (o_wready already low).
- Beats presented in IDLE or DONE are not accepted (o_wready=0); the source must hold them.
- Async reset mid-load: returns to IDLE immediately with outputs cleared. Partial weights are not invalidated; downstream reloads.
- Total accepted beats per load: NW*NUM (150 at default).

Optional Feature:
- Macro: WLOAD_TIMEOUT_EN.
- Defined:
  - An AW-independent stall counter increments each LOAD cycle without an accepted beat and clears on every accepted beat.
  - On reaching TO_CYC-1, FSM -> IDLE, o_err=1 (sticky), no o_done.
  - Abort has priority over timeout in the same cycle; o_err stays 0 in that case.
- Undefined:
  - No stall counter; o_err tied to 0.
  - LOAD waits indefinitely for beats.

Test Plan:
- Reset, then i_start, then 150 back-to-back valid beats with data = beat index mod 256:
  - beat 0 -> o_w_en=6'b000001, addr 0, slice 0=0x00;
  - beat 25 -> o_w_en=6'b000010, addr 0, slice1=0x19;
  - beat 149 -> o_w_en=6'b100000, addr 24, slice5=0x95, o_done=1 in that cycle, then IDLE with o_wready=0.
- i_wvalid toggled 1/0 every cycle over the full load:
  - 150 writes total, in the same order and with the same addr/ch sequence as back-to-back;
  - o_w_en=0 on bubble cycles;
  - completes in about 300 cycles.
- i_abort after 40 accepted beats:
  - last write is ch1/addr14;
  - o_wready drops in the abort cycle;
  - no o_done;
  - a following i_start restarts at ch0/addr0.
- i_start pulsed at beat 60, then a 151st beat presented after o_done:
  - the mid-load start has no effect;
  - the extra beat is not accepted (o_wready=0).
- Async i_rst asserted mid-cycle at beat 77:
  - all outputs 0 immediately, state IDLE;
  - after release with no i_start, o_busy=0 and o_wready=0.
- With WLOAD_TIMEOUT_EN, TO_CYC=16, valid held low for 16 cycles after beat 10:
  - FSM -> IDLE, o_err=1, no o_done;
  - the next i_start clears o_err.
